axil_master: RTL and testbench
==============================

# axil_master

AXI4-Lite master engine that converts single-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions. It returns the read data and response code on a valid/ready response port. It is the initiator counterpart of the team's AXI4-Lite slave and is used by local controllers, bench drivers and bridges to reach register slaves. It allows one transaction in flight and does not reorder.

## Interface
- AWIDTH, 32: address width.
- DWIDTH, 32: data width; must be 32 or 64; strobe width is DWIDTH/8.
- PROT, 3'b000: constant driven on o_awprot and o_arprot.

- i_clock  in  1  rising-edge clock.
- i_areset_n  in  1  reset; synchronous, active-low.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_addr  in  AWIDTH  byte address.
- i_cmd_wdata  in  DWIDTH  write data.
- i_cmd_wstrb  in  DWIDTH/8  write strobes.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_write  out  1  response belongs to a write.
- o_rsp_rdata  out  DWIDTH  read data; zero for writes.
- o_rsp_resp  out  2  BRESP or RRESP.
- o_err  out  1  sticky error flag (see Configuration).
- i_err_clear  in  1  clears o_err.
- AXI channels:
  - AW: o_awaddr[AWIDTH], o_awprot[3], o_awvalid, i_awready.
  - W: o_wdata[DWIDTH], o_wstrb[DWIDTH/8], o_wvalid, i_wready.
  - B: i_bresp[2], i_bvalid, o_bready.
  - AR: o_araddr[AWIDTH], o_arprot[3], o_arvalid, i_arready.
  - R: i_rdata[DWIDTH], i_rresp[2], i_rvalid, o_rready.

## Operation
- The FSM has states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP.
- All outputs except o_awprot and o_arprot are registered.
- IDLE:
  - o_cmd_ready is 1.
  - On a command handshake, the address, data, strobe and direction are captured.
  - A write goes to WR_ADDR_DATA with o_awvalid and o_wvalid both set.
  - A read goes to RD_ADDR with o_arvalid set.
  - o_cmd_ready drops in the same edge.
- WR_ADDR_DATA:
  - AW and W complete independently.
  - o_awvalid clears on the edge where AW handshakes; o_wvalid clears on the edge where W handshakes.
  - When both have completed (including completion in the same cycle), the FSM moves to WR_RESP with o_bready = 1.
- WR_RESP:
  - On i_bvalid, i_bresp is captured and o_rsp_write = 1, o_rsp_rdata = 0.
  - o_bready clears and the FSM moves to RESP.
- RD_ADDR: on an AR handshake, o_arvalid clears, o_rready is set and the FSM moves to RD_DATA.
- RD_DATA:
  - On i_rvalid, i_rdata and i_rresp are captured and o_rsp_write = 0.
  - o_rready clears and the FSM moves to RESP.
- RESP:
  - o_rsp_valid is 1 and the response fields are held stable.
  - On i_rsp_ready, the FSM returns to IDLE with o_cmd_ready = 1 the next cycle.
- Once a VALID is asserted, it and its payload stay stable until the handshake.
- B or R beats arriving outside WR_RESP or RD_DATA are ignored; the corresponding READY is 0 there.
- Unused strobe and data bits are passed through unchanged.

## Timing
- Reset:
  - o_cmd_ready, all VALID and READY outputs, o_rsp_* and o_err are 0.
  - Address and data outputs are 0.
  - The FSM is in IDLE.
  - o_cmd_ready rises on the first edge after reset is released.
- Command handshake at edge N: AW, W or AR VALID is high from cycle N+1.
- With the slave always ready and answering the cycle after its address handshake:
  - The AW/W (or AR) handshake occurs in cycle N+1.
  - B (or R) arrives in cycle N+2.
  - o_rsp_valid rises in cycle N+3.
  - Total: 3 cycles from command to response.
- Throughput with a zero-wait consumer: one transaction every 4 cycles; back-to-back commands are not pipelined.
- Reset asserted mid-transaction:
  - At the next edge all outputs return to their reset values.
  - The transaction is abandoned and no response is issued.
  - The integrator must reset the slave together with this block.
- Write response wait: o_bready is never asserted before both AW and W have completed.

## Configuration
- AXIL_MASTER_ERR_STICKY_EN defined:
  - o_err is set on the edge where a response is captured with resp != 2'b00 (SLVERR or DECERR).
  - o_err is cleared by i_err_clear = 1.
  - If a set and a clear occur in the same cycle, the set wins.
- AXIL_MASTER_ERR_STICKY_EN undefined:
  - o_err is constant 0 and i_err_clear is ignored.
  - o_rsp_resp still reports the slave response code.

## Test plan
- Write 0x0000_0010 / 0xDEAD_BEEF / strb 4'hF, slave always ready, B = OKAY -> AW/W VALID in cycle 1, rsp_valid in cycle 3 with rsp_write = 1, resp = 0, rdata = 0.
- Read 0x0000_0020, arready delayed 3 cycles, R = 0x1234_5678 OKAY -> o_araddr held stable while waiting; rsp_rdata = 0x1234_5678 with o_rsp_resp = 0.
- Write where i_wready comes 2 cycles before i_awready -> o_wvalid drops first, o_awvalid holds, and o_bready rises only after the AW handshake.
- Read with R = SLVERR, then i_err_clear pulsed -> o_rsp_resp = 2'b10.
  - With the macro defined: o_err = 1 until the clear.
  - Without the macro: o_err stays 0.
- Response stalled by i_rsp_ready = 0 for 5 cycles while i_cmd_valid is held -> o_cmd_ready stays 0 and the response holds stable; the next command is accepted 1 cycle after the response handshake.
- Reset asserted while in WR_RESP -> the edge after reset, all VALID/READY outputs are 0 and no response is issued; o_cmd_ready = 1 one cycle after release.

Source files
------------

// File: rtl/axil_master.sv
// rtl/axil_master.sv - AXI4-Lite master: single-word command port to AXI4-Lite, one transaction in flight.
// Optional sticky error flag enabled by defining AXIL_MASTER_ERR_STICKY_EN.
module axil_master #(
  parameter int          AWIDTH = 32,
  parameter int          DWIDTH = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                  i_clock,
  input  logic                  i_areset_n,
  // command port
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [AWIDTH-1:0]     i_cmd_addr,
  input  logic [DWIDTH-1:0]     i_cmd_wdata,
  input  logic [DWIDTH/8-1:0]   i_cmd_wstrb,
  // response port
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [DWIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_err,
  input  logic                  i_err_clear,
  // AW
  output logic [AWIDTH-1:0]     o_awaddr,
  output logic [2:0]            o_awprot,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // W
  output logic [DWIDTH-1:0]     o_wdata,
  output logic [DWIDTH/8-1:0]   o_wstrb,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // B
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  // AR
  output logic [AWIDTH-1:0]     o_araddr,
  output logic [2:0]            o_arprot,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // R
  input  logic [DWIDTH-1:0]     i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [AWIDTH-1:0]     awaddr_q, awaddr_d;
  logic [AWIDTH-1:0]     araddr_q, araddr_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d;
  logic [DWIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  err_q, err_d;
  logic                  rsp_capture;
  logic                  aw_done;
  logic                  w_done;

  // A channel counts as done once its VALID has dropped or it handshakes now.
  assign aw_done = !awvalid_q || i_awready;
  assign w_done  = !wvalid_q  || i_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_ready_q && i_cmd_valid) begin
          cmd_ready_d = 1'b0;
          if (i_cmd_write) begin
            awaddr_d  = i_cmd_addr;
            wdata_d   = i_cmd_wdata;
            wstrb_d   = i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            araddr_d  = i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      WR_ADDR_DATA: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid) begin
          rsp_capture = 1'b1;
          rsp_resp_d  = i_bresp;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          bready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RD_ADDR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_rvalid) begin
          rsp_capture = 1'b1;
          rsp_resp_d  = i_rresp;
          rsp_write_d = 1'b0;
          rsp_rdata_d = i_rdata;
          rsp_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef AXIL_MASTER_ERR_STICKY_EN
  // Set is evaluated after clear so a simultaneous error capture wins.
  always_comb begin
    err_d = err_q;
    if (i_err_clear) err_d = 1'b0;
    if (rsp_capture && (rsp_resp_d != 2'b00)) err_d = 1'b1;
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = i_err_clear ^ rsp_capture;

  always_comb begin
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge i_clock) begin
    if (!i_areset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_awvalid   = awvalid_q;
  assign o_wvalid    = wvalid_q;
  assign o_arvalid   = arvalid_q;
  assign o_bready    = bready_q;
  assign o_rready    = rready_q;
  assign o_awaddr    = awaddr_q;
  assign o_araddr    = araddr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_write = rsp_write_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;
  assign o_err       = err_q;
  assign o_awprot    = PROT;
  assign o_arprot    = PROT;

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - directed self-checking bench for axil_master.
module tb_axil_master;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXIL_MASTER_ERR_STICKY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            err, err_clear;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready, rvalid, rready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axil_master #(.AWIDTH(AW), .DWIDTH(DW), .PROT(3'b000)) dut (
    .i_clock(clk), .i_areset_n(resetn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_err(err), .i_err_clear(err_clear),
    .o_awaddr(awaddr), .o_awprot(awprot), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arprot(arprot), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0; err_clear = 0; awready = 0; wready = 0; bresp = 2'b00; bvalid = 0;
    arready = 0; rdata = '0; rresp = 2'b00; rvalid = 0;

    // reset state
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_prot", {awprot, arprot}, 0);
    resetn = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);

    // write, slave always ready, B one cycle after AW/W
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    chk("w1_c1_awvalid", awvalid, 1);
    chk("w1_c1_wvalid", wvalid, 1);
    chk("w1_c1_awaddr", awaddr, 32'h10);
    chk("w1_c1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_c1_cmd_ready", cmd_ready, 0);
    tick();
    chk("w1_c2_valids", {awvalid, wvalid}, 0);
    chk("w1_c2_bready", bready, 1);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("w1_c3_rsp_valid", rsp_valid, 1);
    chk("w1_c3_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});
    chk("w1_c3_bready", bready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("w1_done", {rsp_valid, cmd_ready}, 2'b01);
    awready = 0; wready = 0;

    // read with arready delayed 3 cycles
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    tick();
    cmd_valid = 0;
    chk("r1_arvalid", arvalid, 1);
    chk("r1_araddr", araddr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_hold", {arvalid, araddr}, {1'b1, 32'h20});
    end
    arready = 1;
    tick();
    arready = 0;
    chk("r1_ar_done", {arvalid, rready}, 2'b01);
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 0;
    chk("r1_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h12345678});
    chk("r1_rready", rready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("r1_done", rsp_valid, 0);

    // write where W completes two cycles before AW
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 32'hA5A50001; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 0;
    chk("w2_wstrb", wstrb, 4'h3);
    wready = 1;
    tick();
    wready = 0;
    chk("w2_w_first", {awvalid, wvalid, bready}, 3'b100);
    tick();
    chk("w2_aw_hold", {awvalid, wvalid, bready, awaddr}, {3'b100, 32'h44});
    awready = 1;
    tick();
    awready = 0;
    chk("w2_aw_done", {awvalid, bready}, 2'b01);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    chk("w2_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read with SLVERR, then clear sticky error
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30; arready = 1;
    tick();
    cmd_valid = 0;
    tick();
    arready = 0;
    rvalid = 1; rdata = 32'h0000CAFE; rresp = 2'b10;
    tick();
    rvalid = 0;
    chk("e_resp", rsp_resp, 2'b10);
    chk("e_err_set", err, EXP_ERR);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("e_err_hold", err, EXP_ERR);
    err_clear = 1;
    tick();
    err_clear = 0;
    chk("e_err_clr", err, 0);

    // response stalled while next command is held
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h50; arready = 1;
    tick();
    cmd_addr = 32'h54;
    tick();
    rvalid = 1; rdata = 32'h11112222; rresp = 2'b00;
    tick();
    rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s_stall", {rsp_valid, cmd_ready, rsp_rdata}, {2'b10, 32'h11112222});
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("s_rsp_done", {rsp_valid, cmd_ready, arvalid}, 3'b010);
    tick();
    cmd_valid = 0;
    chk("s_next_acc", {arvalid, cmd_ready, araddr}, {2'b10, 32'h54});
    tick();
    rvalid = 1; rdata = 32'h33334444;
    tick();
    rvalid = 0;
    chk("s_next_rsp", {rsp_valid, rsp_rdata}, {1'b1, 32'h33334444});
    rsp_ready = 1;
    tick();
    rsp_ready = 0; arready = 0;

    // reset asserted while in WR_RESP
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h60; cmd_wdata = 32'h5; cmd_wstrb = 4'h1;
    awready = 1; wready = 1;
    tick();
    cmd_valid = 0;
    tick();
    awready = 0; wready = 0;
    chk("x_in_wr_resp", bready, 1);
    resetn = 0; bvalid = 1;
    tick();
    chk("x_rst_outs", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
    chk("x_rst_addr", awaddr, 0);
    resetn = 1;
    tick();
    chk("x_rel", {cmd_ready, rsp_valid, bready}, 3'b100);
    tick();
    bvalid = 0;
    chk("x_no_rsp", {rsp_valid, bready}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
